// File: rtl/move_checker_seq_if.sv
// Request, board-read and result signals of the sequential move checker.
// The slave modport is the checker; the master modport is its environment.
interface move_checker_seq_if #(
  parameter int unsigned COORD_W = 3,
  parameter int unsigned PIECE_W = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [2*COORD_W-1:0]   req_start;
  logic [2*COORD_W-1:0]   req_end;
  logic [PIECE_W-1:0]     req_piece;
  logic                   rd_en;
  logic [2*COORD_W-1:0]   rd_addr;
  logic [PIECE_W-1:0]     rd_data;
  logic                   res_valid;
  logic                   res_ready;
  logic                   res_legal;
  logic [2:0]             res_reason;

  modport master (
    output req_valid, req_start, req_end, req_piece, rd_data, res_ready,
    input  req_ready, rd_en, rd_addr, res_valid, res_legal, res_reason
  );

  modport slave (
    input  req_valid, req_start, req_end, req_piece, rd_data, res_ready,
    output req_ready, rd_en, rd_addr, res_valid, res_legal, res_reason
  );
endinterface

// File: rtl/move_checker_seq.sv
// Sequential move legality checker: classifies move geometry, walks the path one
// square per cycle through a synchronous board read port, then checks the destination.
module move_checker_seq #(
  parameter int unsigned COORD_W            = 3,
  parameter int unsigned PIECE_W            = 4,
  parameter bit          REJECT_OWN_CAPTURE = 1'b1
) (
  input logic             clk,
  input logic             reset,
  move_checker_seq_if.slave bus
);
  localparam logic [COORD_W-1:0] MaxCoord = '1;

  localparam logic [2:0] ReasonOk      = 3'd0;
  localparam logic [2:0] ReasonGeom    = 3'd1;
  localparam logic [2:0] ReasonBlocked = 3'd2;
  localparam logic [2:0] ReasonDest    = 3'd3;
  localparam logic [2:0] ReasonNull    = 3'd4;

  localparam logic [2:0] TypeNone   = 3'd0;
  localparam logic [2:0] TypePawn   = 3'd1;
  localparam logic [2:0] TypeKnight = 3'd2;
  localparam logic [2:0] TypeBishop = 3'd3;
  localparam logic [2:0] TypeRook   = 3'd4;
  localparam logic [2:0] TypeQueen  = 3'd5;
  localparam logic [2:0] TypeKing   = 3'd6;
  localparam logic [2:0] TypeBad    = 3'd7;

  typedef enum logic [2:0] {StIdle, StClassify, StWalk, StDest, StResult} state_e;

  state_e               state_q;
  logic [COORD_W-1:0]   sf_q, sr_q, ef_q, er_q;
  logic [PIECE_W-1:0]   piece_q;
  logic [COORD_W-1:0]   cur_f_q, cur_r_q, step_f_q, step_r_q, cnt_q;
  logic                 chk_q, dest_chk_q, pawn_q, diag_q;
  logic [2*COORD_W-1:0] last_addr_q;
  logic                 res_valid_q, res_legal_q;
  logic [2:0]           res_reason_q;

  logic [COORD_W-1:0]   dh, dv, dmax, step_f, step_r, home, n;
  logic [2:0]           ptype;
  logic                 white, is_null, fwd, straight, diag, rook_ok, bishop_ok, geom_ok;
  logic                 occupied, own, walk_hit, dest_ok, issue;
  logic                 unused_bits;

  // Move classification from the latched request.
  always_comb begin
    dh        = (ef_q > sf_q) ? ef_q - sf_q : sf_q - ef_q;
    dv        = (er_q > sr_q) ? er_q - sr_q : sr_q - er_q;
    dmax      = (dh > dv) ? dh : dv;
    step_f    = (ef_q > sf_q) ? COORD_W'(1) : ((ef_q < sf_q) ? MaxCoord : '0);
    step_r    = (er_q > sr_q) ? COORD_W'(1) : ((er_q < sr_q) ? MaxCoord : '0);
    ptype     = piece_q[2:0];
    white     = ~piece_q[PIECE_W-1];
    is_null   = ({er_q, ef_q} == {sr_q, sf_q}) || (ptype == TypeNone) || (ptype == TypeBad);
    fwd       = white ? (er_q > sr_q) : (er_q < sr_q);
    home      = white ? COORD_W'(1) : MaxCoord - COORD_W'(1);
    straight  = fwd && (dh == '0) &&
                ((dv == COORD_W'(1)) || ((dv == COORD_W'(2)) && (sr_q == home)));
    diag      = fwd && (dh == COORD_W'(1)) && (dv == COORD_W'(1));
    rook_ok   = (dh == '0) != (dv == '0);
    bishop_ok = (dh == dv);
    geom_ok   = 1'b0;
    n         = '0;
    case (ptype)
      TypePawn: begin
        geom_ok = straight || diag;
        n       = (straight && (dv == COORD_W'(2))) ? COORD_W'(1) : '0;
      end
      TypeKnight: geom_ok = ((dh == COORD_W'(1)) && (dv == COORD_W'(2))) ||
                            ((dh == COORD_W'(2)) && (dv == COORD_W'(1)));
      TypeBishop: begin
        geom_ok = bishop_ok;
        n       = dmax - COORD_W'(1);
      end
      TypeRook: begin
        geom_ok = rook_ok;
        n       = dmax - COORD_W'(1);
      end
      TypeQueen: begin
        geom_ok = rook_ok || bishop_ok;
        n       = dmax - COORD_W'(1);
      end
      TypeKing: geom_ok = (dmax == COORD_W'(1));
      default: ;
    endcase
  end

  // Board data checks; a blocking piece suppresses the read issued in the same cycle.
  always_comb begin
    occupied = (bus.rd_data[2:0] != TypeNone);
    own      = occupied && (bus.rd_data[PIECE_W-1] == piece_q[PIECE_W-1]);
    walk_hit = chk_q && occupied;
    if (pawn_q) begin
      dest_ok = diag_q ? (occupied && !own) : !occupied;
    end else begin
      dest_ok = !(REJECT_OWN_CAPTURE && own);
    end
    issue = ((state_q == StWalk) || ((state_q == StDest) && !dest_chk_q)) && !walk_hit;
  end

  assign unused_bits    = ^{bus.rd_data, piece_q};
  assign bus.rd_en      = issue;
  assign bus.rd_addr    = !issue ? last_addr_q :
                          (state_q == StDest) ? {er_q, ef_q} : {cur_r_q, cur_f_q};
  assign bus.req_ready  = (state_q == StIdle) && !reset;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_legal  = res_legal_q;
  assign bus.res_reason = res_reason_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      sf_q         <= '0;
      sr_q         <= '0;
      ef_q         <= '0;
      er_q         <= '0;
      piece_q      <= '0;
      cur_f_q      <= '0;
      cur_r_q      <= '0;
      step_f_q     <= '0;
      step_r_q     <= '0;
      cnt_q        <= '0;
      chk_q        <= 1'b0;
      dest_chk_q   <= 1'b0;
      pawn_q       <= 1'b0;
      diag_q       <= 1'b0;
      last_addr_q  <= '0;
      res_valid_q  <= 1'b0;
      res_legal_q  <= 1'b0;
      res_reason_q <= ReasonOk;
    end else begin
      if (issue) last_addr_q <= bus.rd_addr;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid && bus.req_ready) begin
            {sr_q, sf_q} <= bus.req_start;
            {er_q, ef_q} <= bus.req_end;
            piece_q      <= bus.req_piece;
            state_q      <= StClassify;
          end
        end
        StClassify: begin
          pawn_q     <= (ptype == TypePawn);
          diag_q     <= diag;
          step_f_q   <= step_f;
          step_r_q   <= step_r;
          cur_f_q    <= sf_q + step_f;
          cur_r_q    <= sr_q + step_r;
          cnt_q      <= n;
          chk_q      <= 1'b0;
          dest_chk_q <= 1'b0;
          if (is_null || !geom_ok) begin
            res_valid_q  <= 1'b1;
            res_legal_q  <= 1'b0;
            res_reason_q <= is_null ? ReasonNull : ReasonGeom;
            state_q      <= StResult;
          end else begin
            state_q <= (n != '0) ? StWalk : StDest;
          end
        end
        StWalk: begin
          if (walk_hit) begin
            res_valid_q  <= 1'b1;
            res_legal_q  <= 1'b0;
            res_reason_q <= ReasonBlocked;
            state_q      <= StResult;
          end else begin
            cur_f_q <= cur_f_q + step_f_q;
            cur_r_q <= cur_r_q + step_r_q;
            cnt_q   <= cnt_q - COORD_W'(1);
            chk_q   <= 1'b1;
            if (cnt_q == COORD_W'(1)) state_q <= StDest;
          end
        end
        StDest: begin
          if (!dest_chk_q) begin
            if (walk_hit) begin
              res_valid_q  <= 1'b1;
              res_legal_q  <= 1'b0;
              res_reason_q <= ReasonBlocked;
              state_q      <= StResult;
            end else begin
              dest_chk_q <= 1'b1;
              chk_q      <= 1'b0;
            end
          end else begin
            res_valid_q  <= 1'b1;
            res_legal_q  <= dest_ok;
            res_reason_q <= dest_ok ? ReasonOk : ReasonDest;
            state_q      <= StResult;
          end
        end
        StResult: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: doc/move_checker_seq.md
Name: move_checker_seq

Overview:
- Sequential, parametrised move legality checker for the chess engine datapath.
- Accepts one move request per handshake and classifies its geometry by piece type.
- Walks the path one square per cycle through a synchronous board read port, then checks the destination square.
- Returns a legal flag plus a reason code over a valid/ready result handshake.
- Supersedes purely combinational checking against a flat board bus. Board storage is external; this block only reads it.

Parameters:
- COORD_W, 3, bits per file/rank coordinate. The board is 2^COORD_W x 2^COORD_W.
- PIECE_W, 4, piece code width. MSB is colour (0 white, 1 black). Bits [2:0] are type: 0 none, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king. Bits between are reserved and ignored.
- REJECT_OWN_CAPTURE, 1, when 1 a destination holding a same-colour piece is illegal for every piece.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  move request valid
- req_ready  out  1  block can accept a request
- req_start  in  2*COORD_W  source square {rank, file}
- req_end  in  2*COORD_W  destination square {rank, file}
- req_piece  in  PIECE_W  moving piece code
- rd_en  out  1  board read strobe
- rd_addr  out  2*COORD_W  board read address {rank, file}
- rd_data  in  PIECE_W  piece at rd_addr, valid the cycle after rd_en
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_legal  out  1  1 = move legal
- res_reason  out  3  0 OK, 1 GEOM, 2 BLOCKED, 3 DEST, 4 NULL

Behaviour:
- Reset values: req_ready=0 during reset and 1 the cycle after. res_valid=0, res_legal=0, res_reason=0, rd_en=0, rd_addr=0. State returns to IDLE. Any in-flight request is dropped with no result produced.
- States: IDLE, CLASSIFY, WALK, DEST, RESULT.
- IDLE: req_ready=1 only in this state. On req_valid&&req_ready (cycle T), latch start, end and piece, then go to CLASSIFY.
- CLASSIFY (T+1):
  - Compute unsigned abs deltas dh (file) and dv (rank), each COORD_W bits, plus step directions.
  - NULL: start==end or type 0 or 7.
  - GEOM rules:
    - Knight: {dh,dv} is {1,2} or {2,1}.
    - King: max(dh,dv)==1.
    - Rook: exactly one delta nonzero.
    - Bishop: dh==dv.
    - Queen: rook or bishop geometry.
    - Pawn: forward is rank+1 for white, rank-1 for black. Legal pawn shapes are one step forward with dh=0; two steps forward with dh=0 from home rank (1 for white, 2^COORD_W-2 for black); or diagonal one forward with dh=1.
  - On NULL or GEOM failure, go straight to RESULT with no reads issued.
  - Otherwise n = intermediate square count: max(dh,dv)-1 for sliders, 1 for a pawn double step, 0 otherwise.
  - Go to WALK if n>0, else DEST.
- WALK: one rd_en/rd_addr per cycle for squares k=1..n along the step direction. Each cycle also checks rd_data from the previous address. The first nonzero type means BLOCKED: go to RESULT immediately and issue no further reads. After address n, go to DEST.
- DEST: issue read of the end square, check data next cycle.
  - Pawn straight: destination must be empty, else DEST.
  - Pawn diagonal: destination must hold an opposite-colour piece, else DEST.
  - Others: an empty destination passes. An own-colour piece fails with DEST when REJECT_OWN_CAPTURE=1.
  - The last WALK datum is checked in the same cycle the destination address issues.
- Latency, accept at T:
  - NULL/GEOM: res_valid at T+2.
  - Unblocked path: res_valid at T+4+n.
  - Blocked at square k: res_valid at T+3+k.
- RESULT: res_valid, res_legal and res_reason are held stable until res_valid&&res_ready. The next cycle is IDLE with req_ready=1. A request presented during the handshake cycle is not accepted that cycle.
- rd_en is 0 outside WALK/DEST address-issue cycles. rd_addr holds its last value when rd_en=0.
- Coordinates never wrap: direction logic guarantees every walked square lies strictly between start and end.
- Reset asserted mid-WALK with res_ready low: next cycle res_valid=0 and rd_en=0.

Test Plan:
- COORD_W=3, empty board, white rook start 0 → end 56: 6 reads at addresses 8,16,…,48, then 56. res_valid at T+10, legal=1, reason=0.
- Same rook move with a piece at address 24: reads 8, 16, 24, then stop. res_valid at T+6, legal=0, reason=2, no read of 56.
- White knight 1 → 18 with black piece at 18: one read of 18, res_valid at T+4, legal=1. Repeat with white piece at 18: legal=0, reason=3.
- White pawn 12 → 28 (rank 1 home), square 20 empty and square 28 occupied: legal=0, reason=3. Black pawn 52 → 43 with white piece at 43: legal=1.
- Bishop 0 → 10: no reads, res_valid at T+2, reason=1. Piece type 0: reason=4.
- Hold res_ready=0 for 5 cycles: result stable and req_ready=0 throughout. Reset during WALK: res_valid=0 and req_ready=1 the cycle after reset deasserts.
